// File: rtl/bridge_arbiter_if.sv
// Bundle of the two master ports and the shared bridge port seen by bridge_arbiter.
// Handshake: a master raises mN_req with stable addr/wd/be/we and holds them until the
// one-cycle mN_ack pulse; mN_rd is valid during that pulse and held afterwards.
interface bridge_arbiter_if;
  logic        m0_req;
  logic [29:0] m0_addr;
  logic [31:0] m0_wd;
  logic [3:0]  m0_be;
  logic        m0_we;
  logic        m0_ack;
  logic [31:0] m0_rd;

  logic        m1_req;
  logic [29:0] m1_addr;
  logic [31:0] m1_wd;
  logic [3:0]  m1_be;
  logic        m1_we;
  logic        m1_ack;
  logic [31:0] m1_rd;

  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_be, m0_we,
    output m0_ack, m0_rd,
    input  m1_req, m1_addr, m1_wd, m1_be, m1_we,
    output m1_ack, m1_rd,
    output PrAddr, PrWD, PrBE, PrWE, busy,
    input  PrRD
  );

  modport master (
    output m0_req, m0_addr, m0_wd, m0_be, m0_we,
    input  m0_ack, m0_rd,
    output m1_req, m1_addr, m1_wd, m1_be, m1_we,
    input  m1_ack, m1_rd,
    input  PrAddr, PrWD, PrBE, PrWE, busy,
    output PrRD
  );
endinterface

// File: rtl/bridge_arbiter.sv
// Round-robin two-master arbiter sharing one bridge port: IDLE -> XFER (bus cycle)
// -> RESP (ack cycle), with registered read data and a one-cycle ack per master.
module bridge_arbiter #(
  parameter bit RESET_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bridge_arbiter_if.slave  bus,
  output logic [1:0]       dbg_state,
  output logic             dbg_owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rd_q, m0_rd_d;
  logic [31:0] m1_rd_q, m1_rd_d;

  logic        el0, el1, pick;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;
    m0_rd_d  = m0_rd_q;
    m1_rd_d  = m1_rd_q;

    // In RESP the owner's req still belongs to the transfer being acked, so only
    // the other master may compete.
    el0 = bus.m0_req;
    el1 = bus.m1_req;
    if (state_q == S_RESP) begin
      el0 = bus.m0_req & owner_q;
      el1 = bus.m1_req & ~owner_q;
    end
    pick = (el0 & el1) ? ~last_q : el1;

    case (state_q)
      S_IDLE: begin
        if (el0 | el1) begin
          state_d = S_XFER;
          owner_d = pick;
        end
      end
      S_XFER: begin
        state_d = S_RESP;
        last_d  = owner_q;
        if (owner_q) begin
          m1_ack_d = 1'b1;
          m1_rd_d  = bus.PrRD;
        end else begin
          m0_ack_d = 1'b1;
          m0_rd_d  = bus.PrRD;
        end
      end
      S_RESP: begin
        if (el0 | el1) begin
          state_d = S_XFER;
          owner_d = pick;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PrAddr = 30'd0;
    bus.PrWD   = 32'd0;
    bus.PrBE   = 4'd0;
    bus.PrWE   = 1'b0;
    if (state_q == S_XFER) begin
      if (owner_q) begin
        bus.PrAddr = bus.m1_addr;
        bus.PrWD   = bus.m1_wd;
        bus.PrBE   = bus.m1_be;
        bus.PrWE   = bus.m1_we;
      end else begin
        bus.PrAddr = bus.m0_addr;
        bus.PrWD   = bus.m0_wd;
        bus.PrBE   = bus.m0_be;
        bus.PrWE   = bus.m0_we;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= RESET_LAST;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_rd_q  <= 32'd0;
      m1_rd_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
      m0_rd_q  <= m0_rd_d;
      m1_rd_q  <= m1_rd_d;
    end
  end

  assign bus.m0_ack = m0_ack_q;
  assign bus.m1_ack = m1_ack_q;
  assign bus.m0_rd  = m0_rd_q;
  assign bus.m1_rd  = m1_rd_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign dbg_state  = state_q;
  assign dbg_owner  = owner_q;

endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Two-master arbiter in front of the device bridge. It shares the single bridge port between master 0 (CPU data-memory stage) and master 1 (secondary master, e.g. DMA/debug).
- Round-robin grant FSM. Each transfer takes one bus cycle followed by one response cycle, with a registered read-data return and a one-cycle ack pulse per master.
- Placed between CPU/DMA and the bridge; the bridge and devices are unchanged.

Parameters:
- RESET_LAST, 1, master index treated as "last served" after reset, so master 0 wins the first tie.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 transfer request; held high until m0_ack
- m0_addr  in  30  master 0 word address [31:2]
- m0_wd  in  32  master 0 write data
- m0_be  in  4  master 0 byte enables
- m0_we  in  1  master 0 write (1) / read (0)
- m0_ack  out  1  one-cycle pulse: master 0 transfer complete
- m0_rd  out  32  master 0 read data, valid while m0_ack=1, held afterwards
- m1_req, m1_addr, m1_wd, m1_be, m1_we, m1_ack, m1_rd: same as m0_* for master 1
- PrAddr  out  30  bridge word address [31:2]
- PrWD  out  32  bridge write data
- PrBE  out  4  bridge byte enables
- PrWE  out  1  bridge write enable
- PrRD  in  32  bridge read data (combinational from bridge)
- busy  out  1  high in XFER or RESP

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, owner=0, last=RESET_LAST.
  - m0_ack=m1_ack=0; m0_rd=m1_rd=0.
  - Bus outputs are all 0 (PrWE=0); busy=0.
- States: IDLE, XFER, RESP. The state, owner and last registers update only on the rising clk edge.
- Arbitration function (evaluated in IDLE and RESP):
  - Only one eligible requester: that master is chosen.
  - Both eligible: the master != last is chosen.
  - In IDLE both masters are eligible.
  - In RESP only the non-owner is eligible, because the owner's req is stale that cycle.
- IDLE:
  - Bus outputs 0, no ack.
  - Any eligible req: go to XFER with owner=chosen master. Otherwise stay in IDLE.
- XFER (exactly 1 cycle):
  - PrAddr/PrWD/PrBE are driven from the owner's inputs combinationally; PrWE = owner's we.
  - At the clock edge: owner's rd register <= PrRD (captured for writes too; value is don't-care), owner's ack register <= 1, last <= owner, go to RESP.
- RESP (exactly 1 cycle):
  - The owner's ack is 1 and the other ack is 0. Bus outputs are 0 and PrWE=0.
  - Non-owner req: go to XFER with owner=non-owner.
  - Otherwise go to IDLE.
  - The ack register clears at this edge.
- Latency and throughput:
  - req rising in IDLE -> ack 2 cycles later (XFER at edge+1, ack visible after edge+2).
  - One transfer per 2 cycles sustained.
  - Both masters continuously requesting -> grants strictly alternate, no starvation.
- Write semantics: PrWE is high only during XFER, so exactly one write strobe per write transfer. A master never sees a write strobe duplicated.
- Read data: mN_rd is updated only at the edge ending that master's XFER, and holds its value otherwise.
- Master rules:
  - Inputs must be stable from req rise until ack.
  - A master may drop req or present a new request in the cycle after ack. That request is eligible in the next IDLE/RESP evaluation.
  - req dropped before ack is a protocol violation; the arbiter still completes the transfer it launched.
- Simultaneous events: both req rise in the same IDLE cycle -> the master != last wins. After reset, that is master 0.
- Reset mid-operation:
  - Any state -> IDLE immediately (asynchronously).
  - PrWE drops at once, an ack in flight is suppressed, and rd registers clear.
  - An in-progress write may or may not have reached the device.

Test Plan:
- Single read: m0 reads addr 0x7F04 (m0_addr=30'h1FC1) with the bridge returning PrRD=32'hDEADBEEF -> PrAddr=30'h1FC1 and PrWE=0 for one cycle; m0_ack pulses 2 cycles after req; m0_rd=32'hDEADBEEF and holds afterwards.
- Single write: m1 writes 32'h0000_0009 with be=4'hF to 0x7F10 -> exactly one cycle of PrWE=1 with PrAddr=30'h1FC4 and PrWD=32'h9; m1_ack pulses once; m0_ack stays 0.
- Tie after reset: m0_req and m1_req rise in the same cycle -> m0 is granted first, m1 in the next XFER; the acks are 2 cycles apart; sequence is IDLE, XFER0, RESP0, XFER1, RESP1, IDLE.
- Fairness: both masters hold req continuously for 8 transfers -> owners alternate 0,1,0,1,…; each master gets 4 acks; no gap cycle between RESP and XFER.
- Stale-owner exclusion: m0 alone keeps req high across its ack and issues a second request -> after RESP the FSM returns to IDLE, then XFER0 again; exactly 2 acks, never a back-to-back XFER for the same master.
- Async reset: assert reset mid-XFER of a write -> PrWE=0 and all acks=0 within the same cycle; after release both rd=0, state IDLE, and the first tie goes to m0.
